// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//   Bit-serial ALU sequencer. A single 1-bit ALU slice is stepped over WIDTH
//   cycles, LSB first, to perform a WIDTH-bit AND / OR / ADD / SUB / SLT.
//   The ripple carry lives in a flop between bit steps.
//
//   Timing: start accepted at edge E -> busy for WIDTH+1 cycles ->
//   result/zero/done valid in the cycle after edge E+WIDTH+1.
//
// Ports (alu_serial_ctrl):
//   clk       in   1      clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   start     in   1      request, sampled only while idle
//   op        in   3      op[2] invert b / initial carry;
//                         op[1:0] 00 AND, 01 OR, 10 ADD/SUB, 11 SLT
//   a, b      in   WIDTH  operands, captured on accepted start
//   busy      out  1      operation in progress
//   done      out  1      one-cycle pulse, result valid
//   result    out  WIDTH  result, held until the next accepted start
//   zero      out  1      result == 0, registered with result
//   overflow  out  1      only with ALU_SERIAL_OVF_EN: signed overflow of
//                         ADD/SUB, 0 for other ops
//
// Optional feature macro: ALU_SERIAL_OVF_EN
//   Defined   : overflow port present; SLT is corrected for signed overflow.
//   Undefined : no overflow port; SLT uses the raw sign of a-b.
// ---------------------------------------------------------------------------

// 1-bit ALU slice: b inversion, AND/OR/full-add and a pass-through "less"
// input used by SLT on bit 0.
module alu_slice (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic       i_less,
  input  logic       i_binvert,
  input  logic [1:0] i_op,
  output logic       o_result,
  output logic       o_cout,
  output logic       o_set
);

  logic w_b;
  logic w_sum;

  assign w_b    = i_b ^ i_binvert;
  assign w_sum  = i_a ^ w_b ^ i_cin;
  assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);
  assign o_set  = w_sum;

  // Result selection by the low opcode bits
  always_comb begin
    case (i_op)
      2'b00:   o_result = i_a & w_b;
      2'b01:   o_result = i_a | w_b;
      2'b10:   o_result = w_sum;
      default: o_result = i_less;
    endcase
  end

endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_resSh;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CNT_W-1:0] r_index;
  logic             r_msbSet;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;
`ifdef ALU_SERIAL_OVF_EN
  logic             r_msbOvf;
  logic             r_overflow;
`endif

  logic             w_sliceRes;
  logic             w_sliceCout;
  logic             w_sliceSet;
  logic             w_lessBit;
  logic [WIDTH-1:0] w_finalResult;

  // The single shared slice always works on the current LSB of the operand
  // shifters; "less" is tied low because SLT is assembled in FIX instead.
  alu_slice u_slice (
    .i_a       (r_aSh[0]),
    .i_b       (r_bSh[0]),
    .i_cin     (r_carry),
    .i_less    (1'b0),
    .i_binvert (r_op[2]),
    .i_op      (r_op[1:0]),
    .o_result  (w_sliceRes),
    .o_cout    (w_sliceCout),
    .o_set     (w_sliceSet)
  );

  // SLT bit: raw sign of a-b, optionally corrected by the signed overflow
`ifdef ALU_SERIAL_OVF_EN
  assign w_lessBit = r_msbSet ^ r_msbOvf;
`else
  assign w_lessBit = r_msbSet;
`endif

  assign w_finalResult = (r_op[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, w_lessBit}
                                              : r_resSh;

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;
`ifdef ALU_SERIAL_OVF_EN
  assign overflow = r_overflow;
`endif

  // Sequencer: capture operands in IDLE, one slice step per RUN cycle with
  // result bits entering from the MSB side, then a single FIX cycle that
  // publishes result/zero and pulses done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_resSh    <= '0;
      r_op       <= '0;
      r_carry    <= 1'b0;
      r_index    <= '0;
      r_msbSet   <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_done     <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
      r_msbOvf   <= 1'b0;
      r_overflow <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_aSh   <= a;
            r_bSh   <= b;
            r_op    <= op;
            r_carry <= op[2];
            r_index <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_resSh <= {w_sliceRes, r_resSh[WIDTH-1:1]};
          r_carry <= w_sliceCout;
          r_aSh   <= r_aSh >> 1;
          r_bSh   <= r_bSh >> 1;
          r_index <= r_index + CNT_W'(1);
          // On the MSB step the carry-in still holds carry-into-MSB, so the
          // overflow term is available before the carry flop is overwritten.
          if (r_index == LAST_IDX) begin
            r_msbSet <= w_sliceSet;
`ifdef ALU_SERIAL_OVF_EN
            r_msbOvf <= r_carry ^ w_sliceCout;
`endif
            r_state  <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_result   <= w_finalResult;
          r_zero     <= (w_finalResult == '0);
          r_done     <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
          r_overflow <= (r_op[1:0] == 2'b10) & r_msbOvf;
`endif
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
